// File: rtl/index_register_sequencer_pkg.sv
// index_register_sequencer_pkg: op codes, IO encodings and FSM states for the index register sequencer
package index_register_sequencer_pkg;
  localparam int DATA_W = 4;
  localparam int SEL_W = 4;
  localparam logic [2:0] OP_INC = 3'd0;
  localparam logic [2:0] OP_ISZ = 3'd1;
  localparam logic [2:0] OP_XCH = 3'd2;
  localparam logic [2:0] OP_LD = 3'd3;
  localparam logic [2:0] OP_FIM = 3'd4;
  localparam logic [2:0] OP_SRC = 3'd5;
  localparam logic [1:0] IO_WRITE = 2'b00;
  localparam logic [1:0] IO_READ = 2'b01;
  localparam logic [1:0] IO_IDLE = 2'b11;
  typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_WR0, S_WR1, S_DONE} state_e;
  function automatic logic is_legal(input logic [2:0] op);
    return op <= OP_SRC;
  endfunction
endpackage

// File: rtl/index_register_sequencer_if.sv
// index_register_sequencer_if: command/response handshake between the decoder and the sequencer
interface index_register_sequencer_if;
  import index_register_sequencer_pkg::*;
  logic cmd_valid;
  logic cmd_ready;
  logic [2:0] cmd_op;
  logic [SEL_W-1:0] cmd_reg;
  logic [DATA_W-1:0] cmd_acc;
  logic [7:0] cmd_imm;
  logic rsp_valid;
  logic [7:0] rsp_data;
  logic rsp_flag;
  logic rsp_err;
  modport master(output cmd_valid, cmd_op, cmd_reg, cmd_acc, cmd_imm,
                 input cmd_ready, rsp_valid, rsp_data, rsp_flag, rsp_err);
  modport slave(input cmd_valid, cmd_op, cmd_reg, cmd_acc, cmd_imm,
                output cmd_ready, rsp_valid, rsp_data, rsp_flag, rsp_err);
endinterface

// File: rtl/index_register_sequencer.sv
// index_register_sequencer: multi-cycle controller for the 16 x 4-bit index register file
module index_register_sequencer
  import index_register_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  index_register_sequencer_if.slave cmd_if,
  output logic [SEL_W-1:0]  index_register_select_o,
  output logic [1:0]        index_register_IO_o,
  output logic              index_register_I_WE_o,
  output logic [DATA_W-1:0] data_bus_out_o,
  output logic              data_bus_oe_o,
  input  logic [DATA_W-1:0] data_bus_in_i
);
  state_e state_q, state_d;
  logic [2:0] op_q;
  logic [SEL_W-1:0] reg_q;
  logic [DATA_W-1:0] acc_q, t0_q, inc;
  logic [7:0] imm_q, rsp_data_q, rsp_data_d;
  logic rsp_flag_q, rsp_flag_d, rsp_err_q, rsp_err_d;
  logic [SEL_W-1:0] sel0, sel1;
  logic accept;
  assign accept = cmd_if.cmd_valid && state_q == S_IDLE;
  assign inc = t0_q + 4'd1;
  assign sel0 = (op_q == OP_FIM || op_q == OP_SRC) ? {reg_q[SEL_W-1:1], 1'b0} : reg_q;
  assign sel1 = {reg_q[SEL_W-1:1], 1'b1};
  assign cmd_if.cmd_ready = state_q == S_IDLE;
  assign cmd_if.rsp_valid = state_q == S_DONE;
  assign cmd_if.rsp_data = rsp_data_q;
  assign cmd_if.rsp_flag = rsp_flag_q;
  assign cmd_if.rsp_err = rsp_err_q;
  assign data_bus_oe_o = index_register_IO_o == IO_WRITE;
  // Response fields are computed on the edge entering DONE so they are valid with the pulse and then hold.
  always_comb begin
    state_d = state_q;
    rsp_data_d = rsp_data_q;
    rsp_flag_d = rsp_flag_q;
    rsp_err_d = rsp_err_q;
    index_register_select_o = '0;
    index_register_IO_o = IO_IDLE;
    index_register_I_WE_o = 1'b0;
    data_bus_out_o = '0;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = !is_legal(cmd_if.cmd_op) ? S_DONE : cmd_if.cmd_op == OP_FIM ? S_WR0 : S_RD0;
        if (!is_legal(cmd_if.cmd_op)) {rsp_data_d, rsp_flag_d, rsp_err_d} = {8'h00, 1'b0, 1'b1};
      end
      S_RD0: begin
        index_register_select_o = sel0;
        index_register_IO_o = IO_READ;
        state_d = op_q == OP_LD ? S_DONE : op_q == OP_SRC ? S_RD1 : S_WR0;
        if (op_q == OP_LD) {rsp_data_d, rsp_flag_d, rsp_err_d} = {4'h0, data_bus_in_i, 1'b0, 1'b0};
      end
      S_RD1: begin
        index_register_select_o = sel1;
        index_register_IO_o = IO_READ;
        state_d = S_DONE;
        {rsp_data_d, rsp_flag_d, rsp_err_d} = {t0_q, data_bus_in_i, 1'b0, 1'b0};
      end
      S_WR0: begin
        index_register_select_o = sel0;
        index_register_IO_o = IO_WRITE;
        index_register_I_WE_o = 1'b1;
        data_bus_out_o = op_q == OP_XCH ? acc_q : op_q == OP_FIM ? imm_q[7:4] : inc;
        state_d = op_q == OP_FIM ? S_WR1 : S_DONE;
        if (op_q != OP_FIM)
          {rsp_data_d, rsp_flag_d, rsp_err_d} = {4'h0, op_q == OP_XCH ? t0_q : inc, op_q == OP_ISZ && inc != 4'h0, 1'b0};
      end
      S_WR1: begin
        index_register_select_o = sel1;
        index_register_IO_o = IO_WRITE;
        index_register_I_WE_o = 1'b1;
        data_bus_out_o = imm_q[3:0];
        state_d = S_DONE;
        {rsp_data_d, rsp_flag_d, rsp_err_d} = {8'h00, 1'b0, 1'b0};
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q <= '0;
      reg_q <= '0;
      acc_q <= '0;
      imm_q <= '0;
      t0_q <= '0;
      rsp_data_q <= '0;
      rsp_flag_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_flag_q <= rsp_flag_d;
      rsp_err_q <= rsp_err_d;
      if (state_q == S_RD0) t0_q <= data_bus_in_i;
      if (accept) begin
        op_q <= cmd_if.cmd_op;
        reg_q <= cmd_if.cmd_reg;
        acc_q <= cmd_if.cmd_acc;
        imm_q <= cmd_if.cmd_imm;
      end
    end
  end
endmodule

// File: tb/tb_index_register_sequencer.sv
// tb_index_register_sequencer: directed checks of the index register sequencer against a register file model
module tb_index_register_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] sel, dout, din;
  logic [1:0] io;
  logic we, oe;
  logic [3:0] rf [16];
  int tests = 0;
  int fails = 0;
  index_register_sequencer_if ifc();
  index_register_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_if(ifc.slave),
    .index_register_select_o(sel), .index_register_IO_o(io), .index_register_I_WE_o(we),
    .data_bus_out_o(dout), .data_bus_oe_o(oe), .data_bus_in_i(din)
  );
  always #5 clk = ~clk;
  assign din = rf[sel];
  always @(posedge clk) if (we && io == 2'b00) rf[sel] <= dout;
  logic [11:0] bus_v, rsp_v;
  assign bus_v = {sel, io, we, dout, oe};
  assign rsp_v = {ifc.rsp_valid, ifc.rsp_data, ifc.rsp_flag, ifc.rsp_err, ifc.cmd_ready};
  function automatic logic [11:0] bexp(input logic [3:0] s, input logic [1:0] i, input logic w, input logic [3:0] d, input logic o);
    return {s, i, w, d, o};
  endfunction
  function automatic logic [11:0] rexp(input logic v, input logic [7:0] d, input logic f, input logic e, input logic r);
    return {v, d, f, e, r};
  endfunction
  task automatic start(input logic [2:0] op, input logic [3:0] r, input logic [3:0] acc, input logic [7:0] imm);
    @(negedge clk);
    ifc.cmd_valid = 1'b1; ifc.cmd_op = op; ifc.cmd_reg = r; ifc.cmd_acc = acc; ifc.cmd_imm = imm;
    @(posedge clk);
    @(negedge clk);
    ifc.cmd_valid = 1'b0; ifc.cmd_op = 3'd0; ifc.cmd_reg = ~r; ifc.cmd_acc = ~acc; ifc.cmd_imm = ~imm;
  endtask
  task automatic test_reset;
    ifc.cmd_valid = 1'b0; ifc.cmd_op = '0; ifc.cmd_reg = '0; ifc.cmd_acc = '0; ifc.cmd_imm = '0;
    repeat (2) @(negedge clk);
    tests++; if (bus_v !== bexp(4'd0, 2'b11, 1'b0, 4'h0, 1'b0)) begin fails++; $display("FAIL reset_bus got %h want %h", bus_v, bexp(4'd0, 2'b11, 1'b0, 4'h0, 1'b0)); end
    tests++; if (rsp_v !== rexp(1'b0, 8'h00, 1'b0, 1'b0, 1'b1)) begin fails++; $display("FAIL reset_rsp got %h want %h", rsp_v, rexp(1'b0, 8'h00, 1'b0, 1'b0, 1'b1)); end
    rst_n = 1'b1;
  endtask
  task automatic test_fim;
    start(3'd4, 4'd6, 4'h0, 8'hA5);
    tests++; if (bus_v !== bexp(4'd6, 2'b00, 1'b1, 4'hA, 1'b1)) begin fails++; $display("FAIL fim_wr0 got %h want %h", bus_v, bexp(4'd6, 2'b00, 1'b1, 4'hA, 1'b1)); end
    tests++; if (rsp_v !== rexp(1'b0, 8'h00, 1'b0, 1'b0, 1'b0)) begin fails++; $display("FAIL fim_busy got %h want %h", rsp_v, rexp(1'b0, 8'h00, 1'b0, 1'b0, 1'b0)); end
    @(negedge clk);
    tests++; if (bus_v !== bexp(4'd7, 2'b00, 1'b1, 4'h5, 1'b1)) begin fails++; $display("FAIL fim_wr1 got %h want %h", bus_v, bexp(4'd7, 2'b00, 1'b1, 4'h5, 1'b1)); end
    @(negedge clk);
    tests++; if (rsp_v !== rexp(1'b1, 8'h00, 1'b0, 1'b0, 1'b0)) begin fails++; $display("FAIL fim_rsp got %h want %h", rsp_v, rexp(1'b1, 8'h00, 1'b0, 1'b0, 1'b0)); end
    tests++; if (bus_v !== bexp(4'd0, 2'b11, 1'b0, 4'h0, 1'b0)) begin fails++; $display("FAIL fim_done_bus got %h want %h", bus_v, bexp(4'd0, 2'b11, 1'b0, 4'h0, 1'b0)); end
    tests++; if ({rf[6], rf[7]} !== 8'hA5) begin fails++; $display("FAIL fim_rf got %h want a5", {rf[6], rf[7]}); end
  endtask
  task automatic test_src;
    start(3'd5, 4'd7, 4'h0, 8'h00);
    tests++; if (bus_v !== bexp(4'd6, 2'b01, 1'b0, 4'h0, 1'b0)) begin fails++; $display("FAIL src_rd0 got %h want %h", bus_v, bexp(4'd6, 2'b01, 1'b0, 4'h0, 1'b0)); end
    @(negedge clk);
    tests++; if (bus_v !== bexp(4'd7, 2'b01, 1'b0, 4'h0, 1'b0)) begin fails++; $display("FAIL src_rd1 got %h want %h", bus_v, bexp(4'd7, 2'b01, 1'b0, 4'h0, 1'b0)); end
    @(negedge clk);
    tests++; if (rsp_v !== rexp(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0)) begin fails++; $display("FAIL src_rsp got %h want %h", rsp_v, rexp(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0)); end
    @(negedge clk);
    tests++; if (rsp_v !== rexp(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1)) begin fails++; $display("FAIL src_hold got %h want %h", rsp_v, rexp(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1)); end
  endtask
  task automatic test_isz_inc;
    start(3'd4, 4'd2, 4'h0, 8'hF0);
    repeat (2) @(negedge clk);
    start(3'd1, 4'd2, 4'h0, 8'h00);
    tests++; if (bus_v !== bexp(4'd2, 2'b01, 1'b0, 4'h0, 1'b0)) begin fails++; $display("FAIL isz_rd0 got %h want %h", bus_v, bexp(4'd2, 2'b01, 1'b0, 4'h0, 1'b0)); end
    @(negedge clk);
    tests++; if (bus_v !== bexp(4'd2, 2'b00, 1'b1, 4'h0, 1'b1)) begin fails++; $display("FAIL isz_wrap_wr got %h want %h", bus_v, bexp(4'd2, 2'b00, 1'b1, 4'h0, 1'b1)); end
    @(negedge clk);
    tests++; if (rsp_v !== rexp(1'b1, 8'h00, 1'b0, 1'b0, 1'b0)) begin fails++; $display("FAIL isz_wrap_rsp got %h want %h", rsp_v, rexp(1'b1, 8'h00, 1'b0, 1'b0, 1'b0)); end
    start(3'd1, 4'd2, 4'h0, 8'h00);
    @(negedge clk);
    tests++; if (bus_v !== bexp(4'd2, 2'b00, 1'b1, 4'h1, 1'b1)) begin fails++; $display("FAIL isz_wr got %h want %h", bus_v, bexp(4'd2, 2'b00, 1'b1, 4'h1, 1'b1)); end
    @(negedge clk);
    tests++; if (rsp_v !== rexp(1'b1, 8'h01, 1'b1, 1'b0, 1'b0)) begin fails++; $display("FAIL isz_rsp got %h want %h", rsp_v, rexp(1'b1, 8'h01, 1'b1, 1'b0, 1'b0)); end
    tests++; if (rf[2] !== 4'h1) begin fails++; $display("FAIL isz_rf got %h want 1", rf[2]); end
    start(3'd0, 4'd2, 4'h0, 8'h00);
    repeat (2) @(negedge clk);
    tests++; if (rsp_v !== rexp(1'b1, 8'h02, 1'b0, 1'b0, 1'b0)) begin fails++; $display("FAIL inc_rsp got %h want %h", rsp_v, rexp(1'b1, 8'h02, 1'b0, 1'b0, 1'b0)); end
  endtask
  task automatic test_xch_ld;
    start(3'd4, 4'd4, 4'h0, 8'h97);
    repeat (2) @(negedge clk);
    start(3'd2, 4'd4, 4'h3, 8'h00);
    @(negedge clk);
    tests++; if (bus_v !== bexp(4'd4, 2'b00, 1'b1, 4'h3, 1'b1)) begin fails++; $display("FAIL xch_wr got %h want %h", bus_v, bexp(4'd4, 2'b00, 1'b1, 4'h3, 1'b1)); end
    @(negedge clk);
    tests++; if (rsp_v !== rexp(1'b1, 8'h09, 1'b0, 1'b0, 1'b0)) begin fails++; $display("FAIL xch_rsp got %h want %h", rsp_v, rexp(1'b1, 8'h09, 1'b0, 1'b0, 1'b0)); end
    start(3'd3, 4'd4, 4'h0, 8'h00);
    tests++; if (bus_v !== bexp(4'd4, 2'b01, 1'b0, 4'h0, 1'b0)) begin fails++; $display("FAIL ld_rd got %h want %h", bus_v, bexp(4'd4, 2'b01, 1'b0, 4'h0, 1'b0)); end
    @(negedge clk);
    tests++; if (rsp_v !== rexp(1'b1, 8'h03, 1'b0, 1'b0, 1'b0)) begin fails++; $display("FAIL ld_rsp got %h want %h", rsp_v, rexp(1'b1, 8'h03, 1'b0, 1'b0, 1'b0)); end
    start(3'd3, 4'd5, 4'h0, 8'h00);
    @(negedge clk);
    tests++; if (rsp_v !== rexp(1'b1, 8'h07, 1'b0, 1'b0, 1'b0)) begin fails++; $display("FAIL ld_odd_rsp got %h want %h", rsp_v, rexp(1'b1, 8'h07, 1'b0, 1'b0, 1'b0)); end
  endtask
  task automatic test_illegal_back_to_back;
    @(negedge clk);
    ifc.cmd_valid = 1'b1; ifc.cmd_op = 3'd6; ifc.cmd_reg = 4'd1;
    @(negedge clk);
    tests++; if (rsp_v !== rexp(1'b1, 8'h00, 1'b0, 1'b1, 1'b0)) begin fails++; $display("FAIL ill_rsp got %h want %h", rsp_v, rexp(1'b1, 8'h00, 1'b0, 1'b1, 1'b0)); end
    tests++; if (bus_v !== bexp(4'd0, 2'b11, 1'b0, 4'h0, 1'b0)) begin fails++; $display("FAIL ill_bus got %h want %h", bus_v, bexp(4'd0, 2'b11, 1'b0, 4'h0, 1'b0)); end
    @(negedge clk);
    tests++; if (rsp_v !== rexp(1'b0, 8'h00, 1'b0, 1'b1, 1'b1)) begin fails++; $display("FAIL ill_idle got %h want %h", rsp_v, rexp(1'b0, 8'h00, 1'b0, 1'b1, 1'b1)); end
    ifc.cmd_op = 3'd7;
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    tests++; if (rsp_v !== rexp(1'b1, 8'h00, 1'b0, 1'b1, 1'b0)) begin fails++; $display("FAIL ill_again got %h want %h", rsp_v, rexp(1'b1, 8'h00, 1'b0, 1'b1, 1'b0)); end
    @(negedge clk);
    tests++; if (rsp_v !== rexp(1'b0, 8'h00, 1'b0, 1'b1, 1'b1)) begin fails++; $display("FAIL ill_hold got %h want %h", rsp_v, rexp(1'b0, 8'h00, 1'b0, 1'b1, 1'b1)); end
  endtask
  task automatic test_reset_mid_write;
    int seen = 0;
    start(3'd4, 4'd8, 4'h0, 8'h12);
    repeat (2) @(negedge clk);
    start(3'd4, 4'd8, 4'h0, 8'h3C);
    tests++; if (we !== 1'b1) begin fails++; $display("FAIL rst_pre_we got %b want 1", we); end
    #1 rst_n = 1'b0;
    #1;
    tests++; if (bus_v !== bexp(4'd0, 2'b11, 1'b0, 4'h0, 1'b0)) begin fails++; $display("FAIL rst_async_bus got %h want %h", bus_v, bexp(4'd0, 2'b11, 1'b0, 4'h0, 1'b0)); end
    repeat (2) begin @(negedge clk); seen += int'(ifc.rsp_valid); end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); seen += int'(ifc.rsp_valid); end
    tests++; if (seen !== 0) begin fails++; $display("FAIL rst_no_rsp got %0d want 0", seen); end
    tests++; if ({rf[8], rf[9]} !== 8'h12) begin fails++; $display("FAIL rst_rf got %h want 12", {rf[8], rf[9]}); end
    tests++; if (rsp_v !== rexp(1'b0, 8'h00, 1'b0, 1'b0, 1'b1)) begin fails++; $display("FAIL rst_after got %h want %h", rsp_v, rexp(1'b0, 8'h00, 1'b0, 1'b0, 1'b1)); end
  endtask
  initial begin
    test_reset();
    test_fim();
    test_src();
    test_isz_inc();
    test_xch_ld();
    test_illegal_back_to_back();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
